// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared types and pin indices for the bit-serial adder tile
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // uio_in strobe positions
  localparam int BIT_LOAD_A  = 0;
  localparam int BIT_LOAD_B  = 1;
  localparam int BIT_START   = 2;
  localparam int BIT_CLR_ERR = 3;

  // uio_out status positions
  localparam int BIT_CARRY   = 4;
  localparam int BIT_BUSY    = 5;
  localparam int BIT_DONE    = 6;
  localparam int BIT_ERR     = 7;

  // Upper nibble of uio drives status, lower nibble receives strobes
  localparam logic [7:0] UIO_OE = 8'hF0;

endpackage

// File: rtl/serial_add_core.sv
// rtl/serial_add_core.sv - LSB-first serial datapath: operand shifters, carry flop, counter, accumulator
module serial_add_core
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             go,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] acc_next,
  output logic             carry_next,
  output logic             last
);

  // Counter is fixed at 3 bits: WIDTH never exceeds 8, so it never needs to hold more than 7
  localparam logic [2:0] LAST_CNT = 3'(WIDTH - 1);

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] acc;
  logic             carry;
  logic [2:0]       cnt;
  logic             sum_bit;

  // One full-adder step built from the half-adder XOR/AND pair plus the registered carry
  always_comb begin
    sum_bit    = a_sr[0] ^ b_sr[0] ^ carry;
    carry_next = (a_sr[0] & b_sr[0]) | (carry & (a_sr[0] ^ b_sr[0]));
    acc_next   = {sum_bit, acc[WIDTH-1:1]};
    last       = go && (cnt == LAST_CNT);
  end

  // Load seeds a fresh add; go advances one bit per clock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr  <= '0;
      b_sr  <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= 3'd0;
    end else if (load) begin
      a_sr  <= a_in;
      b_sr  <= b_in;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= 3'd0;
    end else if (go) begin
      a_sr  <= a_sr >> 1;
      b_sr  <= b_sr >> 1;
      acc   <= acc_next;
      carry <= carry_next;
      cnt   <= cnt + 3'd1;
    end
  end

endmodule

// File: rtl/tt_um_serial_adder_christ.sv
// rtl/tt_um_serial_adder_christ.sv - TinyTapeout tile: strobe-loaded operands, serial add, held sum and carry
module tt_um_serial_adder_christ
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  output logic [7:0] uo_out
);

  state_t           state;
  logic [3:0]       pin_r;
  logic [3:0]       pin_q;
  logic [3:0]       rise;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [7:0]       sum_q;
  logic             carry_q;
  logic             err;
  logic             any_load;
  logic             start_ok;
  logic             err_set;
  logic [WIDTH-1:0] acc_next;
  logic             carry_next;
  logic             core_last;
  logic             unused_ok;

  assign unused_ok = &{1'b0, ena, uio_in[7:4], ui_in};

  // Register strobes once, then keep a delayed copy so a level-high strobe fires once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pin_r <= 4'd0;
      pin_q <= 4'd0;
    end else begin
      pin_r <= uio_in[3:0];
      pin_q <= pin_r;
    end
  end

  // Decode edges into accepted commands and error events
  always_comb begin
    rise     = pin_r & ~pin_q;
    any_load = rise[BIT_LOAD_A] | rise[BIT_LOAD_B];
    start_ok = (state != RUN) && rise[BIT_START] && !any_load;
    err_set  = ((state == RUN) && (any_load || rise[BIT_START])) ||
               ((state != RUN) && any_load && rise[BIT_START]);
  end

  serial_add_core #(.WIDTH(WIDTH)) u_core (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (start_ok),
    .go         (state == RUN),
    .a_in       (op_a),
    .b_in       (op_b),
    .acc_next   (acc_next),
    .carry_next (carry_next),
    .last       (core_last)
  );

  // Control FSM: operand capture, run sequencing, result latch and sticky error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      op_a    <= '0;
      op_b    <= '0;
      sum_q   <= 8'd0;
      carry_q <= 1'b0;
      err     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (rise[BIT_LOAD_A]) op_a <= ui_in[WIDTH-1:0];
          if (rise[BIT_LOAD_B]) op_b <= ui_in[WIDTH-1:0];
          if (any_load)      state <= IDLE;
          else if (start_ok) state <= RUN;
        end
        RUN: begin
          if (core_last) begin
            state   <= DONE;
            sum_q   <= 8'(acc_next);
            carry_q <= carry_next;
          end
        end
        default: state <= IDLE;
      endcase
      // A set event outranks any clear arriving on the same edge
      if (err_set)                       err <= 1'b1;
      else if (start_ok || rise[BIT_CLR_ERR]) err <= 1'b0;
    end
  end

  // Status pins decode directly from registered state
  always_comb begin
    uio_out              = 8'd0;
    uio_out[BIT_CARRY]   = carry_q;
    uio_out[BIT_BUSY]    = (state == RUN);
    uio_out[BIT_DONE]    = (state == DONE);
    uio_out[BIT_ERR]     = err;
    uio_oe               = UIO_OE;
    uo_out               = sum_q;
  end

endmodule
